// File: rtl/gearbox_arb_pkg.sv
// Shared types and width helpers for the pair-packing arbiter.
package gearbox_arb_pkg;

   typedef enum logic {IDLE, HALF} state_t;

   // Index width for n requesters; never narrower than one bit.
   function automatic int id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Wait counter must hold values up to max_wait; a disabled timeout still gets one bit.
   function automatic int cnt_w(input int max_wait);
      return (max_wait > 0) ? $clog2(max_wait + 1) : 1;
   endfunction

endpackage

// File: rtl/gearbox_pair_arbiter_rr_pick.sv
// Rotate-priority picker: first asserted request at or above ptr, wrapping.
module rr_pick
   import gearbox_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IDW   = id_w(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDW-1:0]   ptr,
   output logic [IDW-1:0]   grant,
   output logic             any
);

   // Scan from the farthest slot back toward ptr so the nearest hit is written last.
   always_comb begin
      grant = '0;
      any   = 1'b0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req[(int'(ptr) + k) % N_REQ]) begin
            grant = IDW'((int'(ptr) + k) % N_REQ);
            any   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/gearbox_pair_arbiter.sv
// Packs two consecutive words from one round-robin-selected requester into a
// single 2*width word; a stalled owner forfeits its half-pair after MAX_WAIT cycles.
module gearbox_pair_arbiter
   import gearbox_arb_pkg::*;
#(
   parameter int width    = 8,
   parameter int N_REQ    = 4,
   parameter int MAX_WAIT = 15
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req_vld,
   input  logic [N_REQ*width-1:0]   req_data,
   output logic [N_REQ-1:0]         req_rdy,
   output logic                     down_vld,
   output logic [2*width-1:0]       down_data,
   output logic [id_w(N_REQ)-1:0]   down_id,
   output logic                     drop
);

   localparam int IDW = id_w(N_REQ);
   localparam int CW  = cnt_w(MAX_WAIT);

   state_t             state_q;
   logic [IDW-1:0]     ptr_q, owner_q, down_id_q;
   logic [CW-1:0]      wait_q;
   logic [width-1:0]   first_q;
   logic [2*width-1:0] down_data_q;
   logic               down_vld_q, drop_q;

   logic [IDW-1:0]     grant, ptr_d;
   logic               any;
   logic               owner_vld, timeout;

   rr_pick #(.N_REQ(N_REQ), .IDW(IDW)) u_pick (
      .req   (req_vld),
      .ptr   (ptr_q),
      .grant (grant),
      .any   (any)
   );

   assign owner_vld = req_vld[owner_q];
   assign timeout   = (MAX_WAIT != 0) && (wait_q == CW'(MAX_WAIT - 1));
   assign ptr_d     = (owner_q == IDW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

   always_comb begin
      req_rdy = '0;
      if (state_q == HALF)
         req_rdy = N_REQ'(1) << owner_q;
      else if (any)
         req_rdy = N_REQ'(1) << grant;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         owner_q     <= '0;
         wait_q      <= '0;
         first_q     <= '0;
         down_vld_q  <= 1'b0;
         down_data_q <= '0;
         down_id_q   <= '0;
         drop_q      <= 1'b0;
      end else begin
         down_vld_q <= 1'b0;
         drop_q     <= 1'b0;
         case (state_q)
            IDLE: begin
               if (any) begin
                  first_q <= req_data[grant*width +: width];
                  owner_q <= grant;
                  wait_q  <= '0;
                  state_q <= HALF;
               end
            end
            HALF: begin
               // A word arriving on the timeout cycle still completes the pair.
               if (owner_vld) begin
                  down_vld_q  <= 1'b1;
                  down_data_q <= {first_q, req_data[owner_q*width +: width]};
                  down_id_q   <= owner_q;
                  ptr_q       <= ptr_d;
                  state_q     <= IDLE;
               end else if (timeout) begin
                  drop_q  <= 1'b1;
                  ptr_q   <= ptr_d;
                  state_q <= IDLE;
               end else if (wait_q != '1) begin
                  wait_q <= wait_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign down_vld  = down_vld_q;
   assign down_data = down_data_q;
   assign down_id   = down_id_q;
   assign drop      = drop_q;

endmodule
